// File: rtl/fila_pkg.sv
// Shared types and constants for the byte-queue front-end arbiter.
package fila_pkg;

    localparam int unsigned FILA_DW          = 8;
    localparam int unsigned FILA_DEPTH       = 8;
    localparam int unsigned FILA_ALMOST_FULL = 6;

    // Three-bit state encoding kept as plain constants for the legacy netlist flow.
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t ENQ      = 3'd1;
    localparam state_t WAIT_ENQ = 3'd2;
    localparam state_t DEQ      = 3'd3;
    localparam state_t WAIT_DEQ = 3'd4;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_t;

endpackage

// File: rtl/fila_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the priority pointer moves only when load is high.
module rr_arbiter2 (
    input  logic clock_10khz,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic load,
    input  logic granted_b,
    output logic grant_b_c
);

    logic prio_b;

    // After a completed grant the other requester gets priority.
    always_ff @(posedge clock_10khz or posedge reset) begin
        if (reset) begin
            prio_b <= 1'b0;
        end else if (load) begin
            prio_b <= ~granted_b;
        end
    end

    assign grant_b_c = req_b & (~req_a | prio_b);

endmodule

// File: rtl/fila_arbiter.sv
// Shares the 8-deep byte queue between producers A/B and one consumer,
// spacing command pulses three cycles apart and tracking occupancy.
module fila_arbiter
    import fila_pkg::*;
#(
    parameter int unsigned DEPTH       = FILA_DEPTH,
    parameter int unsigned ALMOST_FULL = FILA_ALMOST_FULL
) (
    input  logic               clock_10khz,
    input  logic               reset,
    input  logic [FILA_DW-1:0] a_data_in,
    input  logic               a_valid_in,
    output logic               a_ready_out,
    input  logic [FILA_DW-1:0] b_data_in,
    input  logic               b_valid_in,
    output logic               b_ready_out,
    input  logic               deq_req_in,
    output logic [FILA_DW-1:0] deq_data_out,
    output logic               deq_valid_out,
    output logic [FILA_DW-1:0] q_data_out,
    output logic               q_enqueue_out,
    output logic               q_dequeue_out,
    input  logic [FILA_DW-1:0] q_len_in,
    input  logic [FILA_DW-1:0] q_data_in,
    output logic               almost_full_out,
    output logic               err_out
);

    state_t             state_q, state_d;
    op_t                last_op_q, last_op_d;
    logic               grant_b_q, grant_b_d;
    logic [FILA_DW-1:0] shadow_q, shadow_d;

    logic               a_ready_d, b_ready_d;
    logic               q_enqueue_d, q_dequeue_d;
    logic [FILA_DW-1:0] q_data_d, deq_data_d;
    logic               deq_valid_d, almost_full_d, err_d;

    logic               grant_b_c;
    logic               rr_load_c;
    logic               enq_ok_c, deq_ok_c;

    assign enq_ok_c  = (a_valid_in | b_valid_in) & (q_len_in < FILA_DW'(DEPTH));
    assign deq_ok_c  = deq_req_in & (q_len_in != '0);
    assign rr_load_c = (state_q == ENQ);

    rr_arbiter2 u_rr (
        .clock_10khz (clock_10khz),
        .reset       (reset),
        .req_a       (a_valid_in),
        .req_b       (b_valid_in),
        .load        (rr_load_c),
        .granted_b   (grant_b_q),
        .grant_b_c   (grant_b_c)
    );

    // State and registered outputs.
    always_ff @(posedge clock_10khz or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_op_q       <= OP_DEQ;
            grant_b_q       <= 1'b0;
            shadow_q        <= '0;
            a_ready_out     <= 1'b0;
            b_ready_out     <= 1'b0;
            q_enqueue_out   <= 1'b0;
            q_dequeue_out   <= 1'b0;
            q_data_out      <= '0;
            deq_data_out    <= '0;
            deq_valid_out   <= 1'b0;
            almost_full_out <= 1'b0;
            err_out         <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_op_q       <= last_op_d;
            grant_b_q       <= grant_b_d;
            shadow_q        <= shadow_d;
            a_ready_out     <= a_ready_d;
            b_ready_out     <= b_ready_d;
            q_enqueue_out   <= q_enqueue_d;
            q_dequeue_out   <= q_dequeue_d;
            q_data_out      <= q_data_d;
            deq_data_out    <= deq_data_d;
            deq_valid_out   <= deq_valid_d;
            almost_full_out <= almost_full_d;
            err_out         <= err_d;
        end
    end

    // Next state; command outputs are decoded one cycle early so they are flops.
    always_comb begin
        state_d       = state_q;
        last_op_d     = last_op_q;
        grant_b_d     = grant_b_q;
        shadow_d      = shadow_q;
        a_ready_d     = 1'b0;
        b_ready_d     = 1'b0;
        q_enqueue_d   = 1'b0;
        q_dequeue_d   = 1'b0;
        q_data_d      = '0;
        deq_data_d    = deq_data_out;
        deq_valid_d   = 1'b0;
        almost_full_d = almost_full_out;
        err_d         = err_out;

        case (state_q)
            IDLE: begin
                almost_full_d = (q_len_in >= FILA_DW'(ALMOST_FULL));
                if (q_len_in != shadow_q) begin
                    err_d = 1'b1;
                end
                if (enq_ok_c && (!deq_ok_c || last_op_q == OP_DEQ)) begin
                    state_d     = ENQ;
                    grant_b_d   = grant_b_c;
                    q_enqueue_d = 1'b1;
                    a_ready_d   = ~grant_b_c;
                    b_ready_d   = grant_b_c;
                    q_data_d    = grant_b_c ? b_data_in : a_data_in;
                end else if (deq_ok_c) begin
                    state_d     = DEQ;
                    q_dequeue_d = 1'b1;
                end
            end
            ENQ: begin
                state_d = WAIT_ENQ;
            end
            WAIT_ENQ: begin
                state_d   = IDLE;
                last_op_d = OP_ENQ;
                if (shadow_q < FILA_DW'(DEPTH)) begin
                    shadow_d = shadow_q + 8'd1;
                end
            end
            DEQ: begin
                state_d = WAIT_DEQ;
            end
            WAIT_DEQ: begin
                state_d     = IDLE;
                last_op_d   = OP_DEQ;
                deq_data_d  = q_data_in;
                deq_valid_d = 1'b1;
                if (shadow_q != '0) begin
                    shadow_d = shadow_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fila_arbiter.sv
// Directed bench for fila_arbiter with a behavioural 16-entry queue model.
module tb_fila_arbiter;

    logic       clock_10khz;
    logic       reset;
    logic [7:0] a_data_in, b_data_in;
    logic       a_valid_in, b_valid_in;
    logic       a_ready_out, b_ready_out;
    logic       deq_req_in;
    logic [7:0] deq_data_out;
    logic       deq_valid_out;
    logic [7:0] q_data_out;
    logic       q_enqueue_out, q_dequeue_out;
    logic [7:0] q_len_in;
    logic [7:0] q_data_in;
    logic       almost_full_out, err_out;

    fila_arbiter dut (
        .clock_10khz     (clock_10khz),
        .reset           (reset),
        .a_data_in       (a_data_in),
        .a_valid_in      (a_valid_in),
        .a_ready_out     (a_ready_out),
        .b_data_in       (b_data_in),
        .b_valid_in      (b_valid_in),
        .b_ready_out     (b_ready_out),
        .deq_req_in      (deq_req_in),
        .deq_data_out    (deq_data_out),
        .deq_valid_out   (deq_valid_out),
        .q_data_out      (q_data_out),
        .q_enqueue_out   (q_enqueue_out),
        .q_dequeue_out   (q_dequeue_out),
        .q_len_in        (q_len_in),
        .q_data_in       (q_data_in),
        .almost_full_out (almost_full_out),
        .err_out         (err_out)
    );

    initial clock_10khz = 1'b0;
    always #50 clock_10khz = ~clock_10khz;

    // Queue model: registered read data, occupancy optionally skewed by len_bias.
    logic [7:0] qm_mem [0:15];
    logic [3:0] qm_wr, qm_rd;
    logic [7:0] qm_cnt;
    logic [7:0] len_bias;

    always @(posedge clock_10khz or posedge reset) begin
        if (reset) begin
            qm_wr     <= 4'd0;
            qm_rd     <= 4'd0;
            qm_cnt    <= 8'd0;
            q_data_in <= 8'd0;
        end else begin
            if (q_enqueue_out) begin
                qm_mem[qm_wr] <= q_data_out;
                qm_wr         <= qm_wr + 4'd1;
            end
            if (q_dequeue_out) begin
                q_data_in <= qm_mem[qm_rd];
                qm_rd     <= qm_rd + 4'd1;
            end
            qm_cnt <= qm_cnt + 8'(q_enqueue_out) - 8'(q_dequeue_out);
        end
    end

    assign q_len_in = qm_cnt + len_bias;

    int         chk;
    int         errs;
    int         cyc;
    logic [7:0] a_pend[$];
    logic [7:0] b_pend[$];
    int         ev_cyc[$];
    bit         ev_deq[$];
    logic [7:0] ev_dat[$];
    int         strobe_cnt;
    int         a_ready_cnt;
    bit         both_ready;

    task automatic refresh_producers();
        a_valid_in = (a_pend.size() > 0);
        a_data_in  = (a_pend.size() > 0) ? a_pend[0] : 8'd0;
        b_valid_in = (b_pend.size() > 0);
        b_data_in  = (b_pend.size() > 0) ? b_pend[0] : 8'd0;
    endtask

    task automatic clear_logs();
        ev_cyc.delete();
        ev_deq.delete();
        ev_dat.delete();
        strobe_cnt  = 0;
        a_ready_cnt = 0;
        both_ready  = 1'b0;
    endtask

    // Log this cycle's outputs, advance one clock, then retire completed handshakes.
    task automatic tick();
        bit a_fire, b_fire;
        if (q_enqueue_out) begin
            ev_cyc.push_back(cyc); ev_deq.push_back(1'b0); ev_dat.push_back(q_data_out);
        end
        if (q_dequeue_out) begin
            ev_cyc.push_back(cyc); ev_deq.push_back(1'b1); ev_dat.push_back(8'd0);
        end
        if (deq_valid_out) strobe_cnt++;
        if (a_ready_out) a_ready_cnt++;
        if (a_ready_out && b_ready_out) both_ready = 1'b1;
        a_fire = a_valid_in && a_ready_out;
        b_fire = b_valid_in && b_ready_out;
        @(posedge clock_10khz);
        #1;
        cyc++;
        if (a_fire) void'(a_pend.pop_front());
        if (b_fire) void'(b_pend.pop_front());
        refresh_producers();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_pend.delete();
        b_pend.delete();
        refresh_producers();
        deq_req_in = 1'b0;
        len_bias   = 8'd0;
        @(posedge clock_10khz);
        #1;
        reset = 1'b0;
        cyc   = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock_10khz);
        #1;
        chk++; if ({a_ready_out, b_ready_out, q_enqueue_out, q_dequeue_out, deq_valid_out} !== 5'b0) begin
            errs++; $display("FAIL reset_strobes: got %b want 00000", {a_ready_out, b_ready_out, q_enqueue_out, q_dequeue_out, deq_valid_out});
        end
        chk++; if ({q_data_out, deq_data_out} !== 16'h0) begin
            errs++; $display("FAIL reset_data: got %h want 0000", {q_data_out, deq_data_out});
        end
        chk++; if ({almost_full_out, err_out} !== 2'b00) begin
            errs++; $display("FAIL reset_flags: got %b want 00", {almost_full_out, err_out});
        end
        do_reset();
        ticks(3);
        chk++; if (ev_cyc.size() != 0 || err_out !== 1'b0) begin
            errs++; $display("FAIL reset_idle: events %0d err %b want 0 0", ev_cyc.size(), err_out);
        end
    endtask

    task automatic test_single_enqueue();
        do_reset();
        a_pend.push_back(8'h11);
        a_pend.push_back(8'h12);
        refresh_producers();
        tick();
        chk++; if ({q_enqueue_out, a_ready_out, b_ready_out} !== 3'b110) begin
            errs++; $display("FAIL enq1_pulse: enq/ra/rb %b want 110", {q_enqueue_out, a_ready_out, b_ready_out});
        end
        chk++; if (q_data_out !== 8'h11) begin
            errs++; $display("FAIL enq1_data: got %h want 11", q_data_out);
        end
        tick();
        chk++; if (q_len_in !== 8'd1 || q_enqueue_out !== 1'b0 || a_ready_out !== 1'b0) begin
            errs++; $display("FAIL enq1_cycle2: len %0d enq %b ready %b want 1 0 0", q_len_in, q_enqueue_out, a_ready_out);
        end
        tick();
        chk++; if (q_enqueue_out !== 1'b0 || q_data_out !== 8'h00) begin
            errs++; $display("FAIL enq1_recovery: enq %b data %h want 0 00", q_enqueue_out, q_data_out);
        end
        tick();
        chk++; if (q_enqueue_out !== 1'b1 || q_data_out !== 8'h12) begin
            errs++; $display("FAIL enq1_second: enq %b data %h want 1 12", q_enqueue_out, q_data_out);
        end
    endtask

    task automatic test_round_robin();
        int         exp_c[4];
        logic [7:0] exp_d[4];
        exp_c = '{1, 4, 7, 10};
        exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        do_reset();
        a_pend.push_back(8'hA0); a_pend.push_back(8'hA1);
        b_pend.push_back(8'hB0); b_pend.push_back(8'hB1);
        refresh_producers();
        ticks(12);
        chk++; if (ev_cyc.size() != 4) begin
            errs++; $display("FAIL rr_count: got %0d events want 4", ev_cyc.size());
        end
        for (int i = 0; i < 4 && i < ev_cyc.size(); i++) begin
            chk++; if (ev_cyc[i] != exp_c[i] || ev_deq[i] !== 1'b0 || ev_dat[i] !== exp_d[i]) begin
                errs++; $display("FAIL rr_order[%0d]: cyc %0d deq %b data %h want cyc %0d enq %h",
                                 i, ev_cyc[i], ev_deq[i], ev_dat[i], exp_c[i], exp_d[i]);
            end
        end
        chk++; if (both_ready !== 1'b0) begin
            errs++; $display("FAIL rr_both_ready: got %b want 0", both_ready);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 9; i++) a_pend.push_back(8'(8'h20 + i));
        refresh_producers();
        ticks(15);
        chk++; if (almost_full_out !== 1'b0) begin
            errs++; $display("FAIL full_af_low: got %b want 0 at len %0d", almost_full_out, q_len_in);
        end
        ticks(9);
        a_ready_cnt = 0;
        ticks(16);
        chk++; if (q_len_in !== 8'd8 || almost_full_out !== 1'b1) begin
            errs++; $display("FAIL full_level: len %0d af %b want 8 1", q_len_in, almost_full_out);
        end
        chk++; if (a_ready_cnt != 0 || a_valid_in !== 1'b1 || a_data_in !== 8'h28) begin
            errs++; $display("FAIL full_stall: readies %0d valid %b data %h want 0 1 28", a_ready_cnt, a_valid_in, a_data_in);
        end
        deq_req_in = 1'b1;
        tick();
        deq_req_in = 1'b0;
        ticks(9);
        chk++; if (ev_cyc.size() != 10 || ev_dat[9] !== 8'h28 || ev_cyc[9] != 44) begin
            errs++; $display("FAIL full_release: events %0d last cyc %0d want 10 events, 28 at cycle 44",
                             ev_cyc.size(), ev_cyc[ev_cyc.size()-1]);
        end
        chk++; if (deq_data_out !== 8'h20 || q_len_in !== 8'd8 || err_out !== 1'b0) begin
            errs++; $display("FAIL full_after: deq %h len %0d err %b want 20 8 0", deq_data_out, q_len_in, err_out);
        end
    endtask

    task automatic test_empty_and_latency();
        do_reset();
        deq_req_in = 1'b1;
        ticks(6);
        chk++; if (ev_cyc.size() != 0 || strobe_cnt != 0) begin
            errs++; $display("FAIL empty_ignore: events %0d strobes %0d want 0 0", ev_cyc.size(), strobe_cnt);
        end
        deq_req_in = 1'b0;
        a_pend.push_back(8'h5A);
        refresh_producers();
        ticks(4);
        deq_req_in = 1'b1;
        tick();
        deq_req_in = 1'b0;
        chk++; if (q_dequeue_out !== 1'b1) begin
            errs++; $display("FAIL lat_pulse: got %b want 1", q_dequeue_out);
        end
        tick();
        chk++; if (deq_valid_out !== 1'b0 || q_dequeue_out !== 1'b0) begin
            errs++; $display("FAIL lat_early: valid %b deq %b want 0 0", deq_valid_out, q_dequeue_out);
        end
        tick();
        chk++; if (deq_valid_out !== 1'b1 || deq_data_out !== 8'h5A || q_len_in !== 8'd0) begin
            errs++; $display("FAIL lat_strobe: valid %b data %h len %0d want 1 5a 0", deq_valid_out, deq_data_out, q_len_in);
        end
        tick();
        chk++; if (deq_valid_out !== 1'b0 || deq_data_out !== 8'h5A) begin
            errs++; $display("FAIL lat_hold: valid %b data %h want 0 5a", deq_valid_out, deq_data_out);
        end
    endtask

    task automatic test_alternate();
        int exp_c[4];
        bit exp_q[4];
        exp_c = '{13, 16, 19, 22};
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) a_pend.push_back(8'(8'h31 + i));
        refresh_producers();
        ticks(12);
        chk++; if (q_len_in !== 8'd4) begin
            errs++; $display("FAIL alt_fill: len %0d want 4", q_len_in);
        end
        clear_logs();
        for (int i = 0; i < 4; i++) a_pend.push_back(8'(8'h41 + i));
        refresh_producers();
        deq_req_in = 1'b1;
        ticks(12);
        chk++; if (ev_cyc.size() != 4) begin
            errs++; $display("FAIL alt_count: got %0d events want 4", ev_cyc.size());
        end
        for (int i = 0; i < 4 && i < ev_cyc.size(); i++) begin
            chk++; if (ev_cyc[i] != exp_c[i] || ev_deq[i] !== exp_q[i]) begin
                errs++; $display("FAIL alt_order[%0d]: cyc %0d deq %b want cyc %0d deq %b", i, ev_cyc[i], ev_deq[i], exp_c[i], exp_q[i]);
            end
        end
        chk++; if (q_len_in !== 8'd4 || deq_data_out !== 8'h32 || err_out !== 1'b0) begin
            errs++; $display("FAIL alt_state: len %0d deq %h err %b want 4 32 0", q_len_in, deq_data_out, err_out);
        end
        deq_req_in = 1'b0;
    endtask

    task automatic test_reset_mid_deq();
        do_reset();
        a_pend.push_back(8'h77);
        refresh_producers();
        ticks(3);
        deq_req_in = 1'b1;
        tick();
        deq_req_in = 1'b0;
        chk++; if (q_dequeue_out !== 1'b1) begin
            errs++; $display("FAIL mid_deq_pulse: got %b want 1", q_dequeue_out);
        end
        tick();
        reset = 1'b1;
        #1;
        chk++; if ({a_ready_out, b_ready_out, q_enqueue_out, q_dequeue_out, deq_valid_out, deq_data_out, q_data_out} !== 21'h0) begin
            errs++; $display("FAIL mid_reset_outputs: got %h want 0",
                             {a_ready_out, b_ready_out, q_enqueue_out, q_dequeue_out, deq_valid_out, deq_data_out, q_data_out});
        end
        @(posedge clock_10khz);
        #1;
        reset = 1'b0;
        cyc   = 0;
        clear_logs();
        ticks(6);
        chk++; if (strobe_cnt != 0 || ev_cyc.size() != 0 || deq_data_out !== 8'h00) begin
            errs++; $display("FAIL mid_reset_after: strobes %0d events %0d data %h want 0 0 00", strobe_cnt, ev_cyc.size(), deq_data_out);
        end
    endtask

    task automatic test_err_sticky();
        do_reset();
        a_pend.push_back(8'h10);
        refresh_producers();
        ticks(4);
        chk++; if (err_out !== 1'b0) begin
            errs++; $display("FAIL err_clean: got %b want 0", err_out);
        end
        len_bias = 8'd1;
        tick();
        chk++; if (err_out !== 1'b1) begin
            errs++; $display("FAIL err_set: got %b want 1", err_out);
        end
        len_bias = 8'd0;
        ticks(3);
        chk++; if (err_out !== 1'b1) begin
            errs++; $display("FAIL err_sticky: got %b want 1", err_out);
        end
        reset = 1'b1;
        #1;
        chk++; if (err_out !== 1'b0) begin
            errs++; $display("FAIL err_reset: got %b want 0", err_out);
        end
    endtask

    initial begin
        chk        = 0;
        errs       = 0;
        cyc        = 0;
        reset      = 1'b1;
        deq_req_in = 1'b0;
        len_bias   = 8'd0;
        a_data_in  = 8'd0;
        b_data_in  = 8'd0;
        a_valid_in = 1'b0;
        b_valid_in = 1'b0;
        clear_logs();
        test_reset();
        test_single_enqueue();
        test_round_robin();
        test_full();
        test_empty_and_latency();
        test_alternate();
        test_reset_mid_deq();
        test_err_sticky();
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
